// File: rtl/dbg_guv_core.sv
// dbg_guv_core: host-commanded debug governor on the rd/wd AXI-Stream paths (drop, inject, log, pause).
// Latency: ungated channels are combinational passthrough; a command takes effect one edge after START sees it.
// Backpressure: ungated channels forward TREADY upstream; gated channels stall or sink. Optional log path: DBG_GUV_LOG_EN.
module dbg_guv_core #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [28:0]           cmd_in_TDATA,
  input  logic [DATA_WIDTH-1:0] rd_in_TDATA,
  input  logic                  rd_in_TLAST,
  input  logic                  rd_in_TVALID,
  output logic                  rd_in_TREADY,
  output logic [DATA_WIDTH-1:0] rd_out_TDATA,
  output logic                  rd_out_TLAST,
  output logic                  rd_out_TVALID,
  input  logic                  rd_out_TREADY,
  input  logic [DATA_WIDTH-1:0] wd_in_TDATA,
  input  logic                  wd_in_TLAST,
  input  logic                  wd_in_TVALID,
  output logic                  wd_in_TREADY,
  output logic [DATA_WIDTH-1:0] wd_out_TDATA,
  output logic                  wd_out_TLAST,
  output logic                  wd_out_TVALID,
  input  logic                  wd_out_TREADY,
  output logic [DATA_WIDTH-1:0] log_TDATA,
  output logic                  log_TVALID,
  input  logic                  log_TREADY,
  output logic [9:0]            curr_state
);

  typedef enum logic [9:0] {
    S_START       = 10'h001,
    S_DROP        = 10'h002,
    S_INJECT      = 10'h004,
    S_WAIT        = 10'h008,
    S_LOG         = 10'h010,
    S_PAUSE       = 10'h020,
    S_DONE_DROP   = 10'h040,
    S_DONE_LOG    = 10'h080,
    S_DONE_INJECT = 10'h100,
    S_DONE_PAUSE  = 10'h200
  } state_e;

  typedef enum logic [2:0] {A_NONE, A_PAUSE, A_DROP, A_INJECT, A_LOG} act_e;

  // b is cmd[7:1]: b[0] pause, b[2]/b[3] drop rd/wd, b[4]/b[5] inject rd/wd, b[6] log
  function automatic act_e dec_act(input logic [6:0] b);
    act_e a;
    a = A_NONE;
    if (b[0])                 a = A_PAUSE;
    else if (b[2] || b[3])    a = A_DROP;
    else if (b[4] || b[5])    a = A_INJECT;
`ifdef DBG_GUV_LOG_EN
    else if (b[6])            a = A_LOG;
`endif
    return a;
  endfunction

  // Target channel: 0 = rd, 1 = wd. Log always targets rd.
  function automatic logic dec_tgt(input logic [6:0] b);
    logic t;
    t = 1'b0;
    if (b[2])      t = 1'b0;
    else if (b[3]) t = 1'b1;
    else if (b[4]) t = 1'b0;
    else if (b[5]) t = 1'b1;
    return t;
  endfunction

  function automatic state_e act_state(input act_e a);
    state_e s;
    case (a)
      A_DROP:   s = S_DROP;
      A_INJECT: s = S_INJECT;
      A_LOG:    s = S_LOG;
      A_PAUSE:  s = S_PAUSE;
      default:  s = S_START;
    endcase
    return s;
  endfunction

  state_e                state_q, state_d;
  logic [22:0]           cmd_q, cmd_d;        // cmd[23:1]
  logic [1:0]            in_pkt_q, in_pkt_d;
  logic [DATA_WIDTH-1:0] last_rd_q, last_rd_d;

  // Channel views indexed 0 = rd, 1 = wd
  logic [1:0]            in_vld, in_lst, in_rdy, out_vld, out_lst, out_rdy, acc, is_tgt;
  logic [DATA_WIDTH-1:0] in_dat [2];
  logic [DATA_WIDTH-1:0] out_dat [2];

  act_e act_q, live_act;
  logic tgt_q, live_tgt, stall;

  assign in_vld    = {wd_in_TVALID, rd_in_TVALID};
  assign in_lst    = {wd_in_TLAST, rd_in_TLAST};
  assign out_rdy   = {wd_out_TREADY, rd_out_TREADY};
  assign in_dat[0] = rd_in_TDATA;
  assign in_dat[1] = wd_in_TDATA;

  assign rd_in_TREADY  = in_rdy[0];
  assign rd_out_TVALID = out_vld[0];
  assign rd_out_TLAST  = out_lst[0];
  assign rd_out_TDATA  = out_dat[0];
  assign wd_in_TREADY  = in_rdy[1];
  assign wd_out_TVALID = out_vld[1];
  assign wd_out_TLAST  = out_lst[1];
  assign wd_out_TDATA  = out_dat[1];

  assign act_q      = dec_act(cmd_q[6:0]);
  assign tgt_q      = dec_tgt(cmd_q[6:0]);
  assign live_act   = dec_act(cmd_in_TDATA[7:1]);
  assign live_tgt   = dec_tgt(cmd_in_TDATA[7:1]);
  assign is_tgt     = {tgt_q, ~tgt_q};
  assign curr_state = state_q;

  // Per-channel gating; the WAIT exit cycle holds the target so no packet starts under the action
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      in_rdy[ch]  = out_rdy[ch];
      out_vld[ch] = in_vld[ch];
      out_lst[ch] = in_lst[ch];
      out_dat[ch] = in_dat[ch];
      if (state_q == S_PAUSE ||
          (state_q == S_WAIT && is_tgt[ch] && act_q != A_LOG && !in_pkt_q[ch])) begin
        in_rdy[ch]  = 1'b0;
        out_vld[ch] = 1'b0;
      end else if (state_q == S_DROP && is_tgt[ch]) begin
        in_rdy[ch]  = 1'b1;
        out_vld[ch] = 1'b0;
      end else if (state_q == S_INJECT && is_tgt[ch]) begin
        in_rdy[ch]  = 1'b0;
        out_vld[ch] = 1'b1;
        out_lst[ch] = 1'b1;
        out_dat[ch] = {{(DATA_WIDTH-16){1'b0}}, cmd_q[22:7]};
      end
    end
  end

  assign acc   = in_vld & in_rdy;
  assign stall = |(out_vld & ~out_rdy);

  // Packet-boundary tracking and last accepted rd beat
  always_comb begin
    in_pkt_d  = in_pkt_q;
    last_rd_d = last_rd_q;
    for (int ch = 0; ch < 2; ch++) begin
      if (acc[ch]) in_pkt_d[ch] = ~in_lst[ch];
    end
    if (acc[0]) last_rd_d = rd_in_TDATA;
  end

  // Next-state: START latches a command, action states use the latched copy
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_START: begin
        if (cmd_in_TDATA[0] && live_act != A_NONE && !stall) begin
          cmd_d = cmd_in_TDATA[23:1];
          if (live_act == A_PAUSE)
            state_d = S_PAUSE;
          else if (in_pkt_q[live_tgt] || in_vld[live_tgt])
            state_d = S_WAIT;
          else
            state_d = act_state(live_act);
        end
      end
      S_WAIT:   if (!in_pkt_q[tgt_q]) state_d = act_state(act_q);
      S_DROP:   if (acc[tgt_q] && in_lst[tgt_q]) state_d = S_DONE_DROP;
      S_INJECT: if (out_rdy[tgt_q]) state_d = S_DONE_INJECT;
`ifdef DBG_GUV_LOG_EN
      S_LOG:    if (log_TREADY) state_d = S_DONE_LOG;
`else
      S_LOG:    state_d = S_START;
`endif
      S_PAUSE:  if (!cmd_in_TDATA[0] || !cmd_in_TDATA[1]) state_d = S_DONE_PAUSE;
      S_DONE_DROP, S_DONE_LOG, S_DONE_INJECT, S_DONE_PAUSE:
        if (!cmd_in_TDATA[0]) state_d = S_START;
      default:  state_d = S_START;
    endcase
  end

  // Log port
  logic unused_bits;
`ifdef DBG_GUV_LOG_EN
  assign log_TVALID  = (state_q == S_LOG);
  assign log_TDATA   = last_rd_q;
  assign unused_bits = ^{cmd_in_TDATA[28:24], cmd_in_TDATA[2], cmd_q[1]};
`else
  assign log_TVALID  = 1'b0;
  assign log_TDATA   = '0;
  assign unused_bits = ^{cmd_in_TDATA[28:24], cmd_in_TDATA[2], cmd_q[1], cmd_q[6],
                         last_rd_q, log_TREADY};
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_q   <= S_START;
      cmd_q     <= '0;
      in_pkt_q  <= '0;
      last_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      in_pkt_q  <= in_pkt_d;
      last_rd_q <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_dbg_guv_core.sv
// tb_dbg_guv_core: directed vectors for dbg_guv_core with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled after a further settle delay.
// Covers passthrough, START stall, pause, drop, inject (both channels, wait-on-packet), log, reset.
module tb_dbg_guv_core;
  localparam int DW = 64;

  logic          CLOCK_50 = 1'b0;
  logic          rst;
  logic [28:0]   cmd_in_TDATA;
  logic [DW-1:0] rd_in_TDATA, rd_out_TDATA, wd_in_TDATA, wd_out_TDATA, log_TDATA;
  logic          rd_in_TLAST, rd_in_TVALID, rd_in_TREADY, rd_out_TLAST, rd_out_TVALID, rd_out_TREADY;
  logic          wd_in_TLAST, wd_in_TVALID, wd_in_TREADY, wd_out_TLAST, wd_out_TVALID, wd_out_TREADY;
  logic          log_TVALID, log_TREADY;
  logic [9:0]    curr_state;

  int n_chk = 0;
  int n_err = 0;

  dbg_guv_core #(.DATA_WIDTH(DW)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .cmd_in_TDATA(cmd_in_TDATA),
    .rd_in_TDATA(rd_in_TDATA), .rd_in_TLAST(rd_in_TLAST), .rd_in_TVALID(rd_in_TVALID),
    .rd_in_TREADY(rd_in_TREADY), .rd_out_TDATA(rd_out_TDATA), .rd_out_TLAST(rd_out_TLAST),
    .rd_out_TVALID(rd_out_TVALID), .rd_out_TREADY(rd_out_TREADY),
    .wd_in_TDATA(wd_in_TDATA), .wd_in_TLAST(wd_in_TLAST), .wd_in_TVALID(wd_in_TVALID),
    .wd_in_TREADY(wd_in_TREADY), .wd_out_TDATA(wd_out_TDATA), .wd_out_TLAST(wd_out_TLAST),
    .wd_out_TVALID(wd_out_TVALID), .wd_out_TREADY(wd_out_TREADY),
    .log_TDATA(log_TDATA), .log_TVALID(log_TVALID), .log_TREADY(log_TREADY),
    .curr_state(curr_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    rst = 1'b0; cmd_in_TDATA = '0;
    rd_in_TDATA = '0; rd_in_TLAST = 1'b0; rd_in_TVALID = 1'b0; rd_out_TREADY = 1'b1;
    wd_in_TDATA = '0; wd_in_TLAST = 1'b0; wd_in_TVALID = 1'b0; wd_out_TREADY = 1'b1;
    log_TREADY = 1'b0;
    step(); step();
    chk("reset_state", curr_state, 10'h001);
    chk("reset_log_vld", log_TVALID, 1'b0);
    rst = 1'b1;
    step();

    // Passthrough and backpressure forwarding
    rd_in_TDATA = 64'hA5A5_0000_1111_2222; rd_in_TLAST = 1'b1; rd_in_TVALID = 1'b1;
    #1;
    chk("pt_rd_data", rd_out_TDATA, 64'hA5A5_0000_1111_2222);
    chk("pt_rd_vld", rd_out_TVALID, 1'b1);
    chk("pt_rd_last", rd_out_TLAST, 1'b1);
    chk("pt_rd_rdy", rd_in_TREADY, 1'b1);
    rd_out_TREADY = 1'b0;
    #1;
    chk("pt_rd_rdy_bp", rd_in_TREADY, 1'b0);

    // Pause: START holds while a beat is stalled, then pauses both channels
    cmd_in_TDATA = 29'h003;
    step();
    chk("start_stall", curr_state, 10'h001);
    rd_out_TREADY = 1'b1;
    step();
    chk("pause_enter", curr_state, 10'h020);
    wd_in_TVALID = 1'b1;
    #1;
    chk("pause_rd_vld", rd_out_TVALID, 1'b0);
    chk("pause_wd_vld", wd_out_TVALID, 1'b0);
    chk("pause_rd_rdy", rd_in_TREADY, 1'b0);
    for (int i = 0; i < 500; i++) begin
      step();
      if (i % 100 == 99) chk("pause_hold", curr_state, 10'h020);
    end
    chk("pause_end_wd_vld", wd_out_TVALID, 1'b0);
    rd_in_TVALID = 1'b0; wd_in_TVALID = 1'b0;
    cmd_in_TDATA = 29'h002;
    step();
    chk("done_pause", curr_state, 10'h200);
    step();
    chk("pause_to_start", curr_state, 10'h001);
    cmd_in_TDATA = '0;
    step();

    // Drop rd packet
    cmd_in_TDATA = 29'h009;
    step();
    chk("drop_enter", curr_state, 10'h002);
    rd_in_TDATA = 64'hAAAA; rd_in_TLAST = 1'b0; rd_in_TVALID = 1'b1;
    #1;
    chk("drop_a_vld", rd_out_TVALID, 1'b0);
    chk("drop_a_rdy", rd_in_TREADY, 1'b1);
    chk("drop_wd_pt", wd_in_TREADY, 1'b1);
    step();
    chk("drop_mid", curr_state, 10'h002);
    rd_in_TDATA = 64'hBBBB; rd_in_TLAST = 1'b1;
    #1;
    chk("drop_b_vld", rd_out_TVALID, 1'b0);
    step();
    chk("done_drop", curr_state, 10'h040);
    rd_in_TVALID = 1'b0;
    cmd_in_TDATA = '0;
    step();
    chk("drop_to_start", curr_state, 10'h001);
    rd_in_TDATA = 64'hCCCC; rd_in_TLAST = 1'b1; rd_in_TVALID = 1'b1;
    #1;
    chk("after_drop_vld", rd_out_TVALID, 1'b1);
    chk("after_drop_data", rd_out_TDATA, 64'hCCCC);
    step();
    rd_in_TVALID = 1'b0;

    // Inject wd, TVALID held while sink stalls
    wd_out_TREADY = 1'b0;
    cmd_in_TDATA = 29'h00BEEF41;
    step();
    chk("inj_wd_enter", curr_state, 10'h004);
    chk("inj_wd_vld", wd_out_TVALID, 1'b1);
    chk("inj_wd_data", wd_out_TDATA, 64'h0000_0000_0000_BEEF);
    chk("inj_wd_last", wd_out_TLAST, 1'b1);
    chk("inj_wd_in_rdy", wd_in_TREADY, 1'b0);
    chk("inj_rd_pt", rd_in_TREADY, 1'b1);
    step();
    chk("inj_wd_hold", curr_state, 10'h004);
    chk("inj_wd_hold_vld", wd_out_TVALID, 1'b1);
    wd_out_TREADY = 1'b1;
    step();
    chk("done_inject_wd", curr_state, 10'h100);
    chk("done_inject_wd_vld", wd_out_TVALID, 1'b0);
    cmd_in_TDATA = '0;
    step();
    chk("inj_wd_to_start", curr_state, 10'h001);

    // Inject rd mid-packet waits for the TLAST beat
    rd_in_TDATA = 64'hD0D0; rd_in_TLAST = 1'b0; rd_in_TVALID = 1'b1;
    step();
    rd_in_TVALID = 1'b0;
    cmd_in_TDATA = 29'h00123421;
    step();
    chk("wait_enter", curr_state, 10'h008);
    step();
    chk("wait_hold", curr_state, 10'h008);
    rd_in_TDATA = 64'hE0E0; rd_in_TLAST = 1'b1; rd_in_TVALID = 1'b1;
    #1;
    chk("wait_pt_vld", rd_out_TVALID, 1'b1);
    chk("wait_pt_data", rd_out_TDATA, 64'hE0E0);
    step();
    chk("wait_after_last", curr_state, 10'h008);
    rd_in_TVALID = 1'b0;
    step();
    chk("inj_rd_enter", curr_state, 10'h004);
    chk("inj_rd_data", rd_out_TDATA, 64'h1234);
    chk("inj_rd_last", rd_out_TLAST, 1'b1);
    chk("inj_rd_vld", rd_out_TVALID, 1'b1);
    step();
    chk("done_inject_rd", curr_state, 10'h100);
    cmd_in_TDATA = '0;
    step();
    chk("inj_rd_to_start", curr_state, 10'h001);

    // Log last accepted rd beat
    rd_in_TDATA = 64'h1234; rd_in_TLAST = 1'b1; rd_in_TVALID = 1'b1;
    step();
    rd_in_TVALID = 1'b0;
    log_TREADY = 1'b1;
    cmd_in_TDATA = 29'h081;
    step();
`ifdef DBG_GUV_LOG_EN
    chk("log_enter", curr_state, 10'h010);
    chk("log_vld", log_TVALID, 1'b1);
    chk("log_data", log_TDATA, 64'h1234);
    step();
    chk("done_log", curr_state, 10'h080);
    chk("done_log_vld", log_TVALID, 1'b0);
`else
    chk("log_off_state", curr_state, 10'h001);
    chk("log_off_vld", log_TVALID, 1'b0);
    chk("log_off_data", log_TDATA, 64'h0);
    step();
    chk("log_off_stay", curr_state, 10'h001);
`endif
    cmd_in_TDATA = '0;
    log_TREADY = 1'b0;
    step();
    chk("log_to_start", curr_state, 10'h001);

    // Reset in the middle of a wd drop
    cmd_in_TDATA = 29'h011;
    step();
    chk("drop_wd_enter", curr_state, 10'h002);
    wd_in_TDATA = 64'hF00D; wd_in_TLAST = 1'b0; wd_in_TVALID = 1'b1;
    #1;
    chk("drop_wd_rdy", wd_in_TREADY, 1'b1);
    chk("drop_wd_vld", wd_out_TVALID, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("rst_state", curr_state, 10'h001);
    chk("rst_wd_pt_vld", wd_out_TVALID, 1'b1);
    chk("rst_wd_pt_rdy", wd_in_TREADY, 1'b1);
    cmd_in_TDATA = '0; wd_in_TVALID = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_release", curr_state, 10'h001);
    cmd_in_TDATA = 29'h041;
    step();
    chk("rst_cleared_pkt", curr_state, 10'h004);
    step();
    chk("rst_inj_done", curr_state, 10'h100);
    cmd_in_TDATA = '0;
    step();
    chk("final_start", curr_state, 10'h001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
